// File: rtl/dcsk_pkg.sv
// Shared DCSK definitions: word length, chaos generator constants, FSM
// state type and spreading-factor decode. Also used by the demodulator.
package dcsk_pkg;

  localparam int WORDLEN    = 32;
  localparam int LFSR_W     = 16;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  // chip_idx counts up to beta-1 (max 15); bit_idx counts up to WORDLEN-1.
  localparam int CHIP_IDX_W = 4;
  localparam int BIT_IDX_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REF  = 2'd1,
    DATA = 2'd2
  } mod_state_t;

  // Spread_Factor_Sel -> beta: 00=2, 01=4, 10=8, 11=16.
  function automatic logic [4:0] beta_of(input logic [1:0] sel);
    return 5'd2 << sel;
  endfunction

  // Index of the final chip of a half-bit (beta-1), sized for chip_idx.
  function automatic logic [CHIP_IDX_W-1:0] last_chip_of(input logic [1:0] sel);
    return CHIP_IDX_W'(beta_of(sel) - 5'd1);
  endfunction

endpackage

// File: rtl/dcsk_mod_serializer_if.sv
// Word-in / chip-out bus of the DCSK modulator.
// Handshake: a word transfers on a rising Clk edge where In_Valid and
// In_Ready are both 1; In_Data and Spread_Factor_Sel are sampled on that
// same edge. In_Valid is ignored while In_Ready is 0, and the source may
// change In_Data freely while no transfer happens.
// Dbg_State mirrors the modulator FSM for checkers.
interface dcsk_mod_serializer_if;
  import dcsk_pkg::*;

  logic [WORDLEN-1:0] In_Data;
  logic               In_Valid;
  logic               In_Ready;
  logic [1:0]         Spread_Factor_Sel;
  logic               Out_Mod_Data;
  logic               Out_Valid;
  logic               Busy;
  mod_state_t         Dbg_State;

  modport slave (
    input  In_Data, In_Valid, Spread_Factor_Sel,
    output In_Ready, Out_Mod_Data, Out_Valid, Busy, Dbg_State
  );

  modport master (
    output In_Data, In_Valid, Spread_Factor_Sel,
    input  In_Ready, Out_Mod_Data, Out_Valid, Busy, Dbg_State
  );
endinterface

// File: rtl/dcsk_chaos_lfsr.sv
// Fibonacci LFSR used as the chaotic reference source. Chip is the msb of
// the current state; En advances the register by one step.
module dcsk_chaos_lfsr #(
  parameter int           W    = 16,
  parameter logic [W-1:0] SEED = 16'hACE1,
  parameter logic [W-1:0] TAPS = 16'hB400
) (
  input  logic Clk,
  input  logic N_Rst,
  input  logic En,
  output logic Chip
);

  logic [W-1:0] lfsr_q, lfsr_d;

  // Shift left, feeding the parity of the tapped bits into bit 0.
  always_comb begin
    lfsr_d = lfsr_q;
    if (En) begin
      lfsr_d = {lfsr_q[W-2:0], ^(lfsr_q & TAPS)};
    end
  end

  // State register; a non-zero seed keeps the sequence away from all-zeros.
  always_ff @(posedge Clk or negedge N_Rst) begin
    if (!N_Rst) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign Chip = lfsr_q[W-1];

endmodule

// File: rtl/dcsk_mod_serializer.sv
// Binary DCSK modulator. Each info bit (LSB first) is sent as beta chaotic
// reference chips followed by beta data chips (reference repeated for a 1,
// inverted for a 0). The FSM state names the kind of chip currently on the
// registered output, so the output registers are loaded from the next state.
module dcsk_mod_serializer
  import dcsk_pkg::*;
(
  input  logic                 Clk,
  input  logic                 N_Rst,
  dcsk_mod_serializer_if.slave bus
);

  mod_state_t             state_q, state_d;
  logic [CHIP_IDX_W-1:0]  chip_idx_q, chip_idx_d;
  logic [CHIP_IDX_W-1:0]  last_chip_q, last_chip_d;
  logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [WORDLEN-1:0]     word_q, word_d;
  logic [15:0]            ref_buf_q, ref_buf_d;
  logic                   out_chip_q, out_chip_d;
  logic                   out_valid_q, out_valid_d;
  logic                   busy_q, busy_d;
  logic                   lfsr_en, lfsr_chip;
  logic                   in_ready, accept;
  logic                   chip_last, word_last;

  dcsk_chaos_lfsr #(
    .W    (LFSR_W),
    .SEED (LFSR_SEED),
    .TAPS (LFSR_TAPS)
  ) u_lfsr (
    .Clk   (Clk),
    .N_Rst (N_Rst),
    .En    (lfsr_en),
    .Chip  (lfsr_chip)
  );

  assign chip_last = (chip_idx_q == last_chip_q);
  assign word_last = (bit_idx_q == BIT_IDX_W'(WORDLEN - 1));

  // FSM next state, counters and word capture; accept overrides so the
  // final data chip can chain straight into the next word's reference.
  always_comb begin
    state_d     = state_q;
    chip_idx_d  = chip_idx_q;
    bit_idx_d   = bit_idx_q;
    word_d      = word_q;
    last_chip_d = last_chip_q;
    in_ready    = 1'b0;
    case (state_q)
      IDLE: in_ready = 1'b1;
      REF: begin
        if (chip_last) begin
          state_d    = DATA;
          chip_idx_d = '0;
        end else begin
          chip_idx_d = chip_idx_q + 4'd1;
        end
      end
      DATA: begin
        if (chip_last) begin
          chip_idx_d = '0;
          if (!word_last) begin
            bit_idx_d = bit_idx_q + 5'd1;
            state_d   = REF;
          end else begin
            in_ready = 1'b1;
            state_d  = IDLE;
          end
        end else begin
          chip_idx_d = chip_idx_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    accept = in_ready & bus.In_Valid;
    if (accept) begin
      state_d     = REF;
      chip_idx_d  = '0;
      bit_idx_d   = '0;
      word_d      = bus.In_Data;
      last_chip_d = last_chip_of(bus.Spread_Factor_Sel);
    end
  end

  // Chip selection for the cycle being entered: a fresh LFSR chip (also
  // stored for the data half) or a stored reference chip XNOR the info bit.
  always_comb begin
    lfsr_en    = (state_d == REF);
    ref_buf_d  = ref_buf_q;
    out_chip_d = 1'b0;
    case (state_d)
      REF: begin
        out_chip_d            = lfsr_chip;
        ref_buf_d[chip_idx_d] = lfsr_chip;
      end
      DATA:    out_chip_d = ref_buf_q[chip_idx_d] ~^ word_q[bit_idx_d];
      default: out_chip_d = 1'b0;
    endcase
    out_valid_d = (state_d != IDLE);
    busy_d      = (state_d != IDLE);
  end

  // State and output registers; reset aborts any word in flight.
  always_ff @(posedge Clk or negedge N_Rst) begin
    if (!N_Rst) begin
      state_q     <= IDLE;
      chip_idx_q  <= '0;
      bit_idx_q   <= '0;
      last_chip_q <= '0;
      word_q      <= '0;
      ref_buf_q   <= '0;
      out_chip_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      chip_idx_q  <= chip_idx_d;
      bit_idx_q   <= bit_idx_d;
      last_chip_q <= last_chip_d;
      word_q      <= word_d;
      ref_buf_q   <= ref_buf_d;
      out_chip_q  <= out_chip_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.In_Ready     = in_ready;
  assign bus.Out_Mod_Data = out_chip_q;
  assign bus.Out_Valid    = out_valid_q;
  assign bus.Busy         = busy_q;
  assign bus.Dbg_State    = state_q;

endmodule
